// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_ADDR_BITS = 6;
    localparam int DEF_REG_WIDTH = 32;
    localparam int ZERO_REG_ADDR = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of write, reserve and read signals for the scoreboarded register file.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int AW  = DEF_ADDR_BITS,
    parameter int DW  = DEF_REG_WIDTH,
    parameter int NRD = 3
);

    logic              wrEnA;
    logic [AW-1:0]     wrAddrA;
    logic [DW-1:0]     wrDataA;
    logic              wrEnB;
    logic [AW-1:0]     wrAddrB;
    logic [DW-1:0]     wrDataB;
    logic              rsvEn;
    logic [AW-1:0]     rsvAddr;
    logic [NRD*AW-1:0] rdAddr;
    logic [NRD*DW-1:0] rdData;
    logic [NRD-1:0]    rdBusy;
    logic              anyBusy;

    modport master (
        output wrEnA, wrAddrA, wrDataA, wrEnB, wrAddrB, wrDataB,
               rsvEn, rsvAddr, rdAddr,
        input  rdData, rdBusy, anyBusy
    );

    modport slave (
        input  wrEnA, wrAddrA, wrDataA, wrEnB, wrAddrB, wrDataB,
               rsvEn, rsvAddr, rdAddr,
        output rdData, rdBusy, anyBusy
    );

endinterface

// File: rtl/regfile_rdport.sv
// One read port: stored-word mux with same-cycle write bypass and busy lookup.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter  int AW = DEF_ADDR_BITS,
    parameter  int DW = DEF_REG_WIDTH,
    localparam int NR = 2**AW
) (
    input  logic [AW-1:0]         i_addr,
    input  logic [NR-1:0][DW-1:0] i_regs,
    input  logic [NR-1:0]         i_busy,
    input  logic                  i_wr_en_a,
    input  logic [AW-1:0]         i_wr_addr_a,
    input  logic [DW-1:0]         i_wr_data_a,
    input  logic                  i_wr_en_b,
    input  logic [AW-1:0]         i_wr_addr_b,
    input  logic [DW-1:0]         i_wr_data_b,
    input  logic                  i_rsv_en,
    input  logic [AW-1:0]         i_rsv_addr,
    output logic [DW-1:0]         o_data,
    output logic                  o_busy
);

    logic w_zero;
    logic w_hit_a;
    logic w_hit_b;
    logic w_hit_rsv;

    assign w_zero    = (i_addr == AW'(ZERO_REG_ADDR));
    assign w_hit_a   = i_wr_en_a && (i_wr_addr_a == i_addr);
    assign w_hit_b   = i_wr_en_b && (i_wr_addr_b == i_addr);
    assign w_hit_rsv = i_rsv_en  && (i_rsv_addr  == i_addr);

    // Port B is the later writer, so it shadows port A on an address collision.
    assign o_data = w_zero  ? '0          :
                    w_hit_b ? i_wr_data_b :
                    w_hit_a ? i_wr_data_a : i_regs[i_addr];

    // An in-flight write retires the producer unless a new one reserves alongside it.
    assign o_busy = w_zero              ? 1'b0      :
                    (w_hit_a || w_hit_b) ? w_hit_rsv : i_busy[i_addr];

endmodule

// File: rtl/regfile_sb.sv
// Two-write, multi-read register file with a per-register busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int NUM_ADDR_BITS = DEF_ADDR_BITS,
    parameter  int REG_WIDTH     = DEF_REG_WIDTH,
    parameter  int NUM_RD_PORTS  = 3,
    localparam int NUM_REGS      = 2**NUM_ADDR_BITS
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  wrEnA,
    input  logic [NUM_ADDR_BITS-1:0]              wrAddrA,
    input  logic [REG_WIDTH-1:0]                  wrDataA,
    input  logic                                  wrEnB,
    input  logic [NUM_ADDR_BITS-1:0]              wrAddrB,
    input  logic [REG_WIDTH-1:0]                  wrDataB,
    input  logic                                  rsvEn,
    input  logic [NUM_ADDR_BITS-1:0]              rsvAddr,
    input  logic [NUM_RD_PORTS*NUM_ADDR_BITS-1:0] rdAddr,
    output logic [NUM_RD_PORTS*REG_WIDTH-1:0]     rdData,
    output logic [NUM_RD_PORTS-1:0]               rdBusy,
    output logic                                  anyBusy
);

    localparam logic [NUM_ADDR_BITS-1:0] ZA = NUM_ADDR_BITS'(ZERO_REG_ADDR);

    logic [NUM_REGS-1:0][REG_WIDTH-1:0] r_regs;
    logic [NUM_REGS-1:0]                r_busy;
    logic [NUM_REGS-1:0]                w_busy_nxt;

    // Writes retire the producer first, then a reserve re-marks it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wrEnA) w_busy_nxt[wrAddrA] = 1'b0;
        if (wrEnB) w_busy_nxt[wrAddrB] = 1'b0;
        if (rsvEn) w_busy_nxt[rsvAddr] = 1'b1;
        w_busy_nxt[ZA] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs <= '0;
            r_busy <= '0;
        end else begin
            if (wrEnA && wrAddrA != ZA) r_regs[wrAddrA] <= wrDataA;
            if (wrEnB && wrAddrB != ZA) r_regs[wrAddrB] <= wrDataB;
            r_busy <= w_busy_nxt;
        end
    end

    assign anyBusy = |r_busy;

    for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_rd
        regfile_rdport #(
            .AW (NUM_ADDR_BITS),
            .DW (REG_WIDTH)
        ) u_rdport (
            .i_addr      (rdAddr[g*NUM_ADDR_BITS +: NUM_ADDR_BITS]),
            .i_regs      (r_regs),
            .i_busy      (r_busy),
            .i_wr_en_a   (wrEnA),
            .i_wr_addr_a (wrAddrA),
            .i_wr_data_a (wrDataA),
            .i_wr_en_b   (wrEnB),
            .i_wr_addr_b (wrAddrB),
            .i_wr_data_b (wrDataB),
            .i_rsv_en    (rsvEn),
            .i_rsv_addr  (rsvAddr),
            .o_data      (rdData[g*REG_WIDTH +: REG_WIDTH]),
            .o_busy      (rdBusy[g])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector table plus randomized traffic against an array-based model.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int NRD = 3;
    localparam int NRG = 2**AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_sb_if #(.AW(AW), .DW(DW), .NRD(NRD)) bus ();

    regfile_sb #(.NUM_ADDR_BITS(AW), .REG_WIDTH(DW), .NUM_RD_PORTS(NRD)) dut (
        .clk     (clk),
        .reset   (reset),
        .wrEnA   (bus.wrEnA),
        .wrAddrA (bus.wrAddrA),
        .wrDataA (bus.wrDataA),
        .wrEnB   (bus.wrEnB),
        .wrAddrB (bus.wrAddrB),
        .wrDataB (bus.wrDataB),
        .rsvEn   (bus.rsvEn),
        .rsvAddr (bus.rsvAddr),
        .rdAddr  (bus.rdAddr),
        .rdData  (bus.rdData),
        .rdBusy  (bus.rdBusy),
        .anyBusy (bus.anyBusy)
    );

    typedef struct packed {
        logic          rst;
        logic          wea;
        logic [AW-1:0] aa;
        logic [DW-1:0] da;
        logic          web;
        logic [AW-1:0] ab;
        logic [DW-1:0] db;
        logic          rsv;
        logic [AW-1:0] ra;
        logic [AW-1:0] r0, r1, r2;
        logic [DW-1:0] e0, e1, e2;
        logic [2:0]    eb;
        logic          eany;
        logic          chk;
    } vec_t;

    vec_t          vecs[20];
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] m_mem[NRG];
    logic          m_bsy[NRG];

    function automatic vec_t mk(
        input logic rst, wea, input logic [AW-1:0] aa, input logic [DW-1:0] da,
        input logic web, input logic [AW-1:0] ab, input logic [DW-1:0] db,
        input logic rsv, input logic [AW-1:0] ra,
        input logic [AW-1:0] r0, r1, r2, input logic [DW-1:0] e0, e1, e2,
        input logic [2:0] eb, input logic eany, chk);
        vec_t v;
        v = '{rst, wea, aa, da, web, ab, db, rsv, ra, r0, r1, r2, e0, e1, e2, eb, eany, chk};
        return v;
    endfunction

    task automatic cmp(input string nm, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%h want=%h", nm, idx, $time, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset       = v.rst;
        bus.wrEnA   = v.wea;  bus.wrAddrA = v.aa;  bus.wrDataA = v.da;
        bus.wrEnB   = v.web;  bus.wrAddrB = v.ab;  bus.wrDataB = v.db;
        bus.rsvEn   = v.rsv;  bus.rsvAddr = v.ra;
        bus.rdAddr  = {v.r2, v.r1, v.r0};
    endtask

    // Expected read value from the architectural rules: stored word, overridden by
    // any write this cycle (B last), register 0 always zero.
    function automatic logic [DW-1:0] m_data(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = m_mem[a];
        if (bus.wrEnA && bus.wrAddrA == a) d = bus.wrDataA;
        if (bus.wrEnB && bus.wrAddrB == a) d = bus.wrDataB;
        if (a == 0) d = '0;
        return d;
    endfunction

    function automatic logic m_busy(input logic [AW-1:0] a);
        logic b;
        logic wr;
        wr = (bus.wrEnA && bus.wrAddrA == a) || (bus.wrEnB && bus.wrAddrB == a);
        b  = wr ? (bus.rsvEn && bus.rsvAddr == a) : m_bsy[a];
        if (a == 0) b = 1'b0;
        return b;
    endfunction

    function automatic logic m_any();
        logic r;
        r = 1'b0;
        for (int k = 0; k < NRG; k++) r = r | m_bsy[k];
        return r;
    endfunction

    task automatic check_model();
        logic [AW-1:0] a;
        for (int i = 0; i < NRD; i++) begin
            a = bus.rdAddr[i*AW +: AW];
            cmp("rnd_data", i, bus.rdData[i*DW +: DW], m_data(a));
            cmp("rnd_busy", i, DW'(bus.rdBusy[i]), DW'(m_busy(a)));
        end
        cmp("rnd_any", 0, DW'(bus.anyBusy), DW'(m_any()));
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int k = 0; k < NRG; k++) begin
                m_mem[k] = '0;
                m_bsy[k] = 1'b0;
            end
        end else begin
            if (bus.wrEnA) begin
                if (bus.wrAddrA != 0) m_mem[bus.wrAddrA] = bus.wrDataA;
                m_bsy[bus.wrAddrA] = 1'b0;
            end
            if (bus.wrEnB) begin
                if (bus.wrAddrB != 0) m_mem[bus.wrAddrB] = bus.wrDataB;
                m_bsy[bus.wrAddrB] = 1'b0;
            end
            if (bus.rsvEn && bus.rsvAddr != 0) m_bsy[bus.rsvAddr] = 1'b1;
        end
    endtask

    initial begin
        vec_t v;
        for (int k = 0; k < NRG; k++) begin
            m_mem[k] = '0;
            m_bsy[k] = 1'b0;
        end
        //            rst wea aa  da            web ab  db     rsv ra  r0  r1  r2  e0            e1            e2     eb      any chk
        vecs[0]  = mk(1,  0,  0,  0,            0,  0,  0,     0,  0,  0,  5,  63, 0,            0,            0,     3'b000, 0,  0);
        vecs[1]  = mk(0,  0,  0,  0,            0,  0,  0,     0,  0,  0,  5,  63, 0,            0,            0,     3'b000, 0,  1);
        vecs[2]  = mk(0,  1,  5,  32'hDEADBEEF, 0,  0,  0,     0,  0,  5,  0,  63, 32'hDEADBEEF, 0,            0,     3'b000, 0,  1);
        vecs[3]  = mk(0,  0,  0,  0,            0,  0,  0,     0,  0,  5,  5,  0,  32'hDEADBEEF, 32'hDEADBEEF, 0,     3'b000, 0,  1);
        vecs[4]  = mk(0,  1,  7,  32'h11,       1,  7,  32'h22, 0, 0,  7,  5,  0,  32'h22,       32'hDEADBEEF, 0,     3'b000, 0,  1);
        vecs[5]  = mk(0,  0,  0,  0,            0,  0,  0,     0,  0,  7,  7,  5,  32'h22,       32'h22,       32'hDEADBEEF, 3'b000, 0, 1);
        vecs[6]  = mk(0,  0,  0,  0,            0,  0,  0,     1,  9,  9,  7,  0,  0,            32'h22,       0,     3'b000, 0,  1);
        vecs[7]  = mk(0,  0,  0,  0,            0,  0,  0,     0,  0,  9,  9,  0,  0,            0,            0,     3'b011, 1,  1);
        vecs[8]  = mk(0,  0,  0,  0,            1,  9,  32'h55, 0, 0,  9,  5,  0,  32'h55,       32'hDEADBEEF, 0,     3'b000, 1,  1);
        vecs[9]  = mk(0,  0,  0,  0,            0,  0,  0,     0,  0,  9,  9,  7,  32'h55,       32'h55,       32'h22, 3'b000, 0,  1);
        vecs[10] = mk(0,  1,  9,  32'h66,       0,  0,  0,     1,  9,  9,  7,  0,  32'h66,       32'h22,       0,     3'b001, 0,  1);
        vecs[11] = mk(0,  0,  0,  0,            0,  0,  0,     0,  0,  9,  9,  0,  32'h66,       32'h66,       0,     3'b011, 1,  1);
        vecs[12] = mk(0,  0,  0,  0,            0,  0,  0,     1,  9,  9,  0,  7,  32'h66,       0,            32'h22, 3'b001, 1,  1);
        vecs[13] = mk(0,  0,  0,  0,            0,  0,  0,     0,  0,  9,  9,  9,  32'h66,       32'h66,       32'h66, 3'b111, 1,  1);
        vecs[14] = mk(0,  1,  0,  32'hFFFFFFFF, 0,  0,  0,     1,  0,  0,  0,  9,  0,            0,            32'h66, 3'b100, 1,  1);
        vecs[15] = mk(0,  1,  12, 32'hAB,       0,  0,  0,     1,  12, 0,  12, 9,  0,            32'hAB,       32'h66, 3'b110, 1,  1);
        vecs[16] = mk(0,  0,  0,  0,            0,  0,  0,     0,  0,  0,  12, 9,  0,            32'hAB,       32'h66, 3'b110, 1,  1);
        vecs[17] = mk(1,  1,  12, 32'h77,       0,  0,  0,     1,  13, 12, 13, 0,  0,            0,            0,     3'b000, 0,  0);
        vecs[18] = mk(0,  0,  0,  0,            0,  0,  0,     0,  0,  12, 13, 0,  0,            0,            0,     3'b000, 0,  1);
        vecs[19] = mk(0,  0,  0,  0,            0,  0,  0,     0,  0,  9,  5,  7,  0,            0,            0,     3'b000, 0,  1);

        for (int n = 0; n < 20; n++) begin
            drive(vecs[n]);
            @(negedge clk);
            if (vecs[n].chk) begin
                cmp("vec_data0", n, bus.rdData[0*DW +: DW], vecs[n].e0);
                cmp("vec_data1", n, bus.rdData[1*DW +: DW], vecs[n].e1);
                cmp("vec_data2", n, bus.rdData[2*DW +: DW], vecs[n].e2);
                cmp("vec_busy",  n, DW'(bus.rdBusy),  DW'(vecs[n].eb));
                cmp("vec_any",   n, DW'(bus.anyBusy), DW'(vecs[n].eany));
            end
            @(posedge clk);
            model_edge();
            #1;
        end

        // Narrow address range keeps collisions between writes, reserves and reads frequent.
        for (int n = 0; n < 400; n++) begin
            v      = '0;
            v.rst  = ($urandom_range(0, 39) == 0);
            v.wea  = $urandom_range(0, 1) != 0;
            v.aa   = AW'($urandom_range(0, 15));
            v.da   = $urandom;
            v.web  = $urandom_range(0, 2) == 0;
            v.ab   = AW'($urandom_range(0, 15));
            v.db   = $urandom;
            v.rsv  = $urandom_range(0, 1) != 0;
            v.ra   = AW'($urandom_range(0, 15));
            v.r0   = AW'($urandom_range(0, 15));
            v.r1   = AW'($urandom_range(0, 15));
            v.r2   = AW'($urandom_range(0, 63));
            drive(v);
            @(negedge clk);
            if (!v.rst) check_model();
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  NUM_ADDR_BITS  6   register address width
  REG_WIDTH      32  data width
  NUM_RD_PORTS   3   read port count, 1..8
  NUM_REGS       2**NUM_ADDR_BITS  register count, derived and not overridden
REQ-002 Ports SHALL be (name, direction, width, meaning), with clock and reset first:
  clk        in   1                           single clock; all state updates on its rising edge
  reset      in   1                           synchronous, active-high reset
  wrEnA      in   1                           write port A enable
  wrAddrA    in   NUM_ADDR_BITS               write port A address
  wrDataA    in   REG_WIDTH                   write port A data
  wrEnB      in   1                           write port B enable
  wrAddrB    in   NUM_ADDR_BITS               write port B address
  wrDataB    in   REG_WIDTH                   write port B data
  rsvEn      in   1                           reserve (mark busy) enable
  rsvAddr    in   NUM_ADDR_BITS               register to reserve
  rdAddr     in   NUM_RD_PORTS*NUM_ADDR_BITS  packed read addresses; port i at [i*NUM_ADDR_BITS +: NUM_ADDR_BITS]
  rdData     out  NUM_RD_PORTS*REG_WIDTH      packed read data, packed the same way
  rdBusy     out  NUM_RD_PORTS                per-port busy flag for the addressed register
  anyBusy    out  1                           OR of all scoreboard bits

Function
REQ-003 Storage SHALL be NUM_REGS words of REG_WIDTH plus one busy bit per register.
REQ-004 Register 0 SHALL read as zero and never be busy; writes and reserves to address 0 SHALL be ignored.
REQ-005 Writes SHALL commit on the rising clk edge when the enable is high.
REQ-006 When wrEnA and wrEnB target the same address in the same cycle, port B data SHALL be stored.
REQ-007 Reads SHALL be combinational, with same-cycle bypass: if an enabled write in the current cycle targets rdAddr[i] (nonzero), rdData[i] SHALL return that write data (B over A), otherwise stored data.
REQ-008 An enabled write to register r SHALL clear busy[r] at the clock edge.
REQ-009 rsvEn SHALL set busy[rsvAddr] at the clock edge.
REQ-010 If reserve and write target the same register in one cycle, data SHALL be written and busy SHALL end up set (the new producer wins).
REQ-011 rdBusy[i] SHALL equal busy[rdAddr[i]] after same-cycle bypass: a current-cycle write to that address gives 0 unless a same-address reserve is also present.
REQ-012 Reserving an already-busy register SHALL leave it busy; no error is flagged.
REQ-013 Outputs SHALL settle combinationally; there is no read latency, and write-to-stored-read latency is 1 cycle.

Reset
REQ-014 While reset is high at a clock edge, all registers SHALL clear to 0 and all busy bits to 0.
REQ-015 Writes and reserves presented during a reset cycle SHALL be ignored.
REQ-016 After reset, rdData SHALL be all-zero, rdBusy SHALL be 0 and anyBusy SHALL be 0.
REQ-017 Reset asserted mid-operation SHALL discard all pending reservations.

Structure
REQ-018 A shared package regfile_pkg SHALL hold the default NUM_ADDR_BITS and REG_WIDTH constants and the zero-register address constant.
REQ-019 A single sub-module regfile_rdport SHALL implement one read port (mux, bypass, busy lookup) and SHALL be instantiated NUM_RD_PORTS times by a generate loop.

Verification
REQ-020 Reset, then read all ports at addresses 0, 5 and 63 -> rdData = 0 on every port; rdBusy = 0; anyBusy = 0.
REQ-021 wrEnA, addr 5, 0xDEADBEEF; same cycle read port 0 at addr 5 -> bypass gives 0xDEADBEEF; next cycle with no write -> still 0xDEADBEEF.
REQ-022 wrEnA addr 7 = 0x11 and wrEnB addr 7 = 0x22 in the same cycle -> bypass read shows 0x22 and stored value is 0x22.
REQ-023 rsvEn addr 9 -> rdBusy=1 and anyBusy=1 next cycle; wrEnB addr 9 = 0x55 -> same-cycle rdBusy=0, next cycle busy clear and data 0x55.
REQ-024 rsvEn addr 9 plus wrEnA addr 9 = 0x66 in the same cycle -> data 0x66 stored and busy[9] = 1 afterwards.
REQ-025 Write 0xFFFFFFFF and reserve at addr 0, then assert reset while addr 12 is busy and holds 0xAB -> addr 0 reads 0 and is not busy; after reset addr 12 = 0 and anyBusy = 0.
